// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: issues loads/stores over req/gnt/rvalid,
// aligns store data, extracts load data, and owns the MEM/WB pipeline register.
module mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  mem_we_i,
  input  logic                  wdata_mux_i,
  input  logic [2:0]            mem_size_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic                  reg_we_i,
  input  logic [ADDR_WIDTH-1:0] dest_reg_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic                  dmem_we_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic                  wb_reg_we_o,
  output logic [ADDR_WIDTH-1:0] wb_dest_reg_o,
  output logic [DATA_WIDTH-1:0] wb_wdata_o,
  output logic                  misaligned_o
);

  typedef enum logic {IDLE = 1'b0, WAIT_RVALID = 1'b1} state_t;

  state_t                  r_state;
  logic [1:0]              r_off;
  logic [2:0]              r_size;
  logic                    r_reg_we;
  logic [ADDR_WIDTH-1:0]   r_dest;
  logic                    r_wb_valid;
  logic                    r_wb_reg_we;
  logic [ADDR_WIDTH-1:0]   r_wb_dest;
  logic [DATA_WIDTH-1:0]   r_wb_wdata;
  logic                    r_misaligned;

  logic                    w_mem_op;
  logic                    w_load;
  logic [1:0]              w_off;
  logic                    w_misaligned;
  logic                    w_req;
  logic                    w_ready;
  logic                    w_accept;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_st_data;

  // Shift the addressed lane down to bit 0 and sign/zero-extend by funct3.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0] off,
                                               input logic [2:0] size);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (size)
      3'b000:  load_extract = {{24{s[7]}}, s[7:0]};
      3'b100:  load_extract = {24'h000000, s[7:0]};
      3'b001:  load_extract = {{16{s[15]}}, s[15:0]};
      3'b101:  load_extract = {16'h0000, s[15:0]};
      default: load_extract = s;
    endcase
  endfunction

  assign w_mem_op = mem_we_i | wdata_mux_i;
  assign w_load   = wdata_mux_i & ~mem_we_i;
  assign w_off    = alu_result_i[1:0];

  // Alignment check and store lane/data steering from the access size.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_st_data    = mem_wdata_i;
    case (mem_size_i[1:0])
      2'b00: begin
        w_be      = 4'b0001 << w_off;
        w_st_data = {4{mem_wdata_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = w_mem_op & w_off[0];
        w_be         = 4'b0011 << w_off;
        w_st_data    = {2{mem_wdata_i[15:0]}};
      end
      default: begin
        w_misaligned = w_mem_op & (w_off != 2'b00);
        w_be         = 4'b1111;
        w_st_data    = mem_wdata_i;
      end
    endcase
  end

  assign w_req = ~rst & (r_state == IDLE) & in_valid_i & w_mem_op & ~w_misaligned;

  // Instruction is consumed when no memory wait is pending for it.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:        w_ready = ~w_mem_op | w_misaligned | (w_req & mem_we_i & dmem_gnt_i);
      WAIT_RVALID: w_ready = dmem_rvalid_i;
      default:     w_ready = 1'b0;
    endcase
  end

  assign w_accept     = in_valid_i & w_ready;
  assign in_ready_o   = w_ready;
  assign dmem_req_o   = w_req;
  assign dmem_addr_o  = {alu_result_i[31:2], 2'b00};
  assign dmem_we_o    = mem_we_i;
  assign dmem_be_o    = mem_we_i ? w_be : 4'b1111;
  assign dmem_wdata_o = w_st_data;

  // Access FSM and MEM/WB register; data fields hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_off        <= 2'b00;
      r_size       <= 3'b000;
      r_reg_we     <= 1'b0;
      r_dest       <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_reg_we  <= 1'b0;
      r_wb_dest    <= '0;
      r_wb_wdata   <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_wb_valid   <= w_accept;
      r_misaligned <= w_accept & (r_state == IDLE) & w_misaligned;
      case (r_state)
        IDLE: begin
          if (w_req & w_load & dmem_gnt_i) begin
            r_off    <= w_off;
            r_size   <= mem_size_i;
            r_reg_we <= reg_we_i;
            r_dest   <= dest_reg_i;
            r_state  <= WAIT_RVALID;
          end else begin
            r_state  <= IDLE;
          end
          if (w_accept) begin
            r_wb_reg_we <= reg_we_i & ~w_misaligned;
            r_wb_dest   <= dest_reg_i;
            r_wb_wdata  <= alu_result_i;
          end else begin
            r_wb_reg_we <= r_wb_reg_we;
          end
        end
        WAIT_RVALID: begin
          if (dmem_rvalid_i) begin
            r_wb_reg_we <= r_reg_we;
            r_wb_dest   <= r_dest;
            r_wb_wdata  <= load_extract(dmem_rdata_i, r_off, r_size);
            r_state     <= IDLE;
          end else begin
            r_state     <= WAIT_RVALID;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb_valid_o    = r_wb_valid;
  assign wb_reg_we_o   = r_wb_reg_we;
  assign wb_dest_reg_o = r_wb_dest;
  assign wb_wdata_o    = r_wb_wdata;
  assign misaligned_o  = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU passthrough, stores, loads,
// load wait, misaligned access and reset during an outstanding load.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] alu_result_i;
  logic        mem_we_i;
  logic        wdata_mux_i;
  logic [2:0]  mem_size_i;
  logic [31:0] mem_wdata_i;
  logic        reg_we_i;
  logic [4:0]  dest_reg_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_reg_we_o;
  logic [4:0]  wb_dest_reg_o;
  logic [31:0] wb_wdata_o;
  logic        misaligned_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_result_i(alu_result_i), .mem_we_i(mem_we_i), .wdata_mux_i(wdata_mux_i),
    .mem_size_i(mem_size_i), .mem_wdata_i(mem_wdata_i), .reg_we_i(reg_we_i),
    .dest_reg_i(dest_reg_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_reg_we_o(wb_reg_we_o), .wb_dest_reg_o(wb_dest_reg_o),
    .wb_wdata_o(wb_wdata_o), .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid_i = 1'b1; mem_we_i = 1'b0; wdata_mux_i = 1'b1;
    mem_size_i = 3'b010; alu_result_i = 32'h0000_1000; mem_wdata_i = 32'h0;
    reg_we_i = 1'b1; dest_reg_i = 5'd3; dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    tick; tick;
    n_checks++;
    if (dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", dmem_req_o); end
    n_checks++;
    if ({wb_valid_o, wb_reg_we_o, wb_dest_reg_o, wb_wdata_o, misaligned_o} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_wb got v=%b we=%b rd=%0d d=%h mis=%b want all 0",
               wb_valid_o, wb_reg_we_o, wb_dest_reg_o, wb_wdata_o, misaligned_o);
    end
    in_valid_i = 1'b0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_alu_passthrough;
    in_valid_i = 1'b1; mem_we_i = 1'b0; wdata_mux_i = 1'b0;
    alu_result_i = 32'h1234_5678; reg_we_i = 1'b1; dest_reg_i = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready_o !== 1'b1 || dmem_req_o !== 1'b0) begin
        n_fail++; $display("FAIL alu_ready[%0d] got rdy=%b req=%b want 1/0", i, in_ready_o, dmem_req_o);
      end
      tick;
      n_checks++;
      if (wb_valid_o !== 1'b1 || wb_wdata_o !== 32'h1234_5678 || wb_dest_reg_o !== 5'd5 || wb_reg_we_o !== 1'b1) begin
        n_fail++;
        $display("FAIL alu_wb[%0d] got v=%b d=%h rd=%0d we=%b want 1/12345678/5/1",
                 i, wb_valid_o, wb_wdata_o, wb_dest_reg_o, wb_reg_we_o);
      end
    end
    in_valid_i = 1'b0;
    tick;
    n_checks++;
    if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %b want 0", wb_valid_o); end
  endtask

  task automatic test_store_byte;
    in_valid_i = 1'b1; mem_we_i = 1'b1; wdata_mux_i = 1'b0; mem_size_i = 3'b000;
    alu_result_i = 32'h0000_1003; mem_wdata_i = 32'h0000_00AB; reg_we_i = 1'b0;
    dest_reg_i = 5'd0; dmem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dmem_gnt_i = (i == 2) ? 1'b1 : 1'b0;
      #1;
      n_checks++;
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h0000_1000 || dmem_be_o !== 4'b1000 ||
          dmem_wdata_o !== 32'hABAB_ABAB || dmem_we_o !== 1'b1 || in_ready_o !== (i == 2)) begin
        n_fail++;
        $display("FAIL sb_req[%0d] got req=%b a=%h be=%b wd=%h we=%b rdy=%b want 1/00001000/1000/abababab/1/%0d",
                 i, dmem_req_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o, in_ready_o, (i == 2));
      end
      tick;
      if (i < 2) begin
        n_checks++;
        if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL sb_stall[%0d] wb_valid got %b want 0", i, wb_valid_o); end
      end
    end
    in_valid_i = 1'b0; dmem_gnt_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_reg_we_o !== 1'b0) begin
      n_fail++; $display("FAIL sb_wb got v=%b we=%b want 1/0", wb_valid_o, wb_reg_we_o);
    end
    tick;
  endtask

  task automatic test_store_half;
    in_valid_i = 1'b1; mem_we_i = 1'b1; wdata_mux_i = 1'b0; mem_size_i = 3'b001;
    alu_result_i = 32'h0000_2002; mem_wdata_i = 32'hDEAD_BEEF; dmem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (dmem_be_o !== 4'b1100 || dmem_wdata_o !== 32'hBEEF_BEEF || dmem_addr_o !== 32'h0000_2000) begin
      n_fail++; $display("FAIL sh_lane got be=%b wd=%h a=%h want 1100/beefbeef/00002000", dmem_be_o, dmem_wdata_o, dmem_addr_o);
    end
    tick;
    in_valid_i = 1'b0; dmem_gnt_i = 1'b0;
    tick;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] rdata, input logic [31:0] exp, input int waits);
    in_valid_i = 1'b1; mem_we_i = 1'b0; wdata_mux_i = 1'b1; mem_size_i = size;
    alu_result_i = addr; reg_we_i = 1'b1; dest_reg_i = 5'd7; dmem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b1 || dmem_be_o !== 4'b1111 || dmem_we_o !== 1'b0 || in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL ld_req a=%h got req=%b be=%b we=%b rdy=%b want 1/1111/0/0",
                         addr, dmem_req_o, dmem_be_o, dmem_we_o, in_ready_o);
    end
    tick;
    dmem_gnt_i = 1'b0;
    for (int i = 0; i < waits; i++) begin
      #1;
      n_checks++;
      if (in_ready_o !== 1'b0 || dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL ld_wait[%0d] got rdy=%b req=%b v=%b want 0/0/0", i, in_ready_o, dmem_req_o, wb_valid_o);
      end
      tick;
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ld_rvalid got rdy=%b v=%b want 1/0", in_ready_o, wb_valid_o);
    end
    tick;
    dmem_rvalid_i = 1'b0; in_valid_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_wdata_o !== exp || wb_reg_we_o !== 1'b1 || wb_dest_reg_o !== 5'd7) begin
      n_fail++; $display("FAIL ld_wb a=%h sz=%b got v=%b d=%h we=%b rd=%0d want 1/%h/1/7",
                         addr, size, wb_valid_o, wb_wdata_o, wb_reg_we_o, wb_dest_reg_o, exp);
    end
    tick;
    n_checks++;
    if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL ld_after got v=%b want 0", wb_valid_o); end
  endtask

  task automatic test_loads;
    do_load(32'h0000_3001, 3'b000, 32'h80FF_7F01, 32'h0000_007F, 0);
    do_load(32'h0000_3002, 3'b000, 32'h80FF_7F01, 32'hFFFF_FFFF, 0);
    do_load(32'h0000_3002, 3'b001, 32'h80FF_7F01, 32'hFFFF_80FF, 0);
    do_load(32'h0000_3002, 3'b101, 32'h80FF_7F01, 32'h0000_80FF, 0);
    do_load(32'h0000_3003, 3'b100, 32'h80FF_7F01, 32'h0000_0080, 0);
    do_load(32'h0000_3000, 3'b010, 32'h80FF_7F01, 32'h80FF_7F01, 0);
  endtask

  task automatic test_load_wait;
    do_load(32'h0000_4000, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, 2);
  endtask

  task automatic test_misaligned;
    in_valid_i = 1'b1; mem_we_i = 1'b0; wdata_mux_i = 1'b1; mem_size_i = 3'b010;
    alu_result_i = 32'h0000_1002; reg_we_i = 1'b1; dest_reg_i = 5'd9; dmem_gnt_i = 1'b0;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL mis_req got req=%b rdy=%b want 0/1", dmem_req_o, in_ready_o);
    end
    tick;
    in_valid_i = 1'b0;
    n_checks++;
    if (misaligned_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_reg_we_o !== 1'b0) begin
      n_fail++; $display("FAIL mis_wb got mis=%b v=%b we=%b want 1/1/0", misaligned_o, wb_valid_o, wb_reg_we_o);
    end
    tick;
    n_checks++;
    if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got %b want 0", misaligned_o); end
    in_valid_i = 1'b1; mem_size_i = 3'b101; alu_result_i = 32'h0000_1001;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL mis_lhu got req=%b rdy=%b want 0/1", dmem_req_o, in_ready_o);
    end
    tick;
    in_valid_i = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_load;
    in_valid_i = 1'b1; mem_we_i = 1'b0; wdata_mux_i = 1'b1; mem_size_i = 3'b010;
    alu_result_i = 32'h0000_5000; reg_we_i = 1'b1; dest_reg_i = 5'd11; dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0; in_valid_i = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if ({wb_valid_o, wb_reg_we_o, wb_dest_reg_o, wb_wdata_o, misaligned_o} !== 40'h0) begin
      n_fail++; $display("FAIL rml_reset got v=%b we=%b rd=%0d d=%h mis=%b want all 0",
                         wb_valid_o, wb_reg_we_o, wb_dest_reg_o, wb_wdata_o, misaligned_o);
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    tick;
    dmem_rvalid_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b0 || wb_wdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rml_stale got v=%b d=%h want 0/00000000", wb_valid_o, wb_wdata_o);
    end
    in_valid_i = 1'b1; wdata_mux_i = 1'b0; alu_result_i = 32'h0000_00AA;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rml_idle ready got %b want 1", in_ready_o); end
    tick;
    in_valid_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_wdata_o !== 32'h0000_00AA) begin
      n_fail++; $display("FAIL rml_after got v=%b d=%h want 1/000000aa", wb_valid_o, wb_wdata_o);
    end
  endtask

  initial begin
    test_reset;
    test_alu_passthrough;
    test_store_byte;
    test_store_half;
    test_loads;
    test_load_wait;
    test_misaligned;
    test_reset_mid_load;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the write-back stage. The block issues loads and stores to the data memory over a req/gnt/rvalid handshake, generating byte enables and aligning store data. It extracts and sign/zero-extends load data, detects misaligned accesses, and stalls the upstream pipeline until each memory access completes. Its output register is the MEM/WB pipeline register and feeds the register-file write port.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and memory word width. Only 32 is supported.
- ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid_i  input  1  EX/MEM register holds a valid instruction.
- in_ready_o  output  1  the instruction is consumed this cycle. Upstream holds all inputs stable while in_valid_i && !in_ready_o.
- alu_result_i  input  32  effective address for load/store; write-back data otherwise.
- mem_we_i  input  1  instruction is a store.
- wdata_mux_i  input  1  1 = load (WDATA_MEM), 0 = ALU result (WDATA_ALU).
- mem_size_i  input  3  funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- mem_wdata_i  input  32  store data, unaligned (rs2).
- reg_we_i  input  1  instruction writes rd.
- dest_reg_i  input  ADDR_WIDTH  rd.
- dmem_req_o  output  1  memory request.
- dmem_gnt_i  input  1  request accepted this cycle.
- dmem_addr_o  output  32  word-aligned address: {alu_result_i[31:2], 2'b00}.
- dmem_we_o  output  1  write request.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  32  lane-aligned store data.
- dmem_rvalid_i  input  1  read data valid.
- dmem_rdata_i  input  32  read word.
- wb_valid_o  output  1  MEM/WB register holds a valid instruction.
- wb_reg_we_o  output  1  register write enable.
- wb_dest_reg_o  output  ADDR_WIDTH  rd.
- wb_wdata_o  output  32  write-back data.
- misaligned_o  output  1  registered one-cycle pulse with the faulting instruction's wb_valid_o.

## Operation
- Memory op: mem_we_i || wdata_mux_i. Offset off = alu_result_i[1:0].
- Misaligned: off != 0 for size 010; off[0] for size 001/101. A misaligned op issues no request. It is accepted immediately and passed to WB with wb_reg_we_o=0 and misaligned_o=1.
- Byte enables:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
  - dmem_be_o is 1111 for loads.
- Store data: byte is replicated ×4; half is replicated ×2; word is passed unchanged.
- Load extract: the word is shifted right by 8*off, then:
  - LB sign-extends bit 7.
  - LBU zero-extends.
  - LH sign-extends bit 15.
  - LHU zero-extends.
  - LW is passed unchanged.
- FSM states IDLE and WAIT_RVALID:
  - IDLE with an aligned memory op: dmem_req_o=1, outputs driven combinationally from the inputs, held until dmem_gnt_i.
    - Store with gnt: accepted, stay in IDLE.
    - Load with gnt: latch off, size and dest, then go to WAIT_RVALID.
  - WAIT_RVALID: dmem_req_o=0. On rvalid: accept, capture the extracted data, return to IDLE.
- in_ready_o is asserted in these cases:
  - IDLE and the instruction is a non-memory op.
  - IDLE and the op is misaligned.
  - IDLE, store, and gnt.
  - WAIT_RVALID and rvalid.
- Non-memory op: wb_wdata_o = alu_result_i, with reg_we and dest passed through.
- wb_valid_o = in_valid_i && in_ready_o, registered. It is 0 when not accepted, which makes it a bubble.
- dmem_rvalid_i in IDLE is ignored.

## Timing
- Reset values: wb_valid_o=0, wb_reg_we_o=0, wb_dest_reg_o=0, wb_wdata_o=0, misaligned_o=0, FSM=IDLE. dmem_req_o=0 while rst=1.
- Reset mid-load: the FSM is forced to IDLE, and a later stale rvalid is ignored.
- Latency, from acceptance to wb_valid_o:
  - Non-memory op: output the cycle after acceptance.
  - Store: output the cycle after the gnt cycle.
  - Load: output the cycle after the rvalid cycle. With gnt in cycle N and rvalid in N+1, wb_valid_o is high in N+2.
- A stall holds the MEM/WB register's data fields. wb_valid_o drops to 0 during a stall.
- Back-to-back non-memory ops sustain one instruction per cycle.

## Test plan
- ALU passthrough: alu_result_i=0x12345678, reg_we=1, rd=5, three consecutive cycles -> wb_valid_o=1 for three cycles, wdata=0x12345678, rd=5, in_ready_o=1 throughout.
- Store byte: SB at 0x1003 with wdata 0x000000AB, gnt delayed 2 cycles -> req held 3 cycles, addr=0x1000, be=1000, dmem_wdata=0xABABABAB, we=1, in_ready_o=0 for 2 cycles, wb_valid_o=1 with reg_we=0 one cycle after gnt.
- Signed/unsigned loads: rdata=0x80FF7F01.
  - LB at off 1 -> 0x0000007F.
  - LB at off 2 -> 0xFFFFFFFF.
  - LH at off 2 -> 0xFFFF80FF.
  - LHU at off 2 -> 0x000080FF.
  - LW -> 0x80FF7F01.
  - Each result appears one cycle after rvalid.
- Load wait: gnt in cycle N, rvalid in N+3 -> in_ready_o=0 in N..N+2, 1 in N+3, wb_valid_o=1 only in N+4.
- Misaligned: LW at 0x1002 -> no dmem_req_o, in_ready_o=1 the same cycle, next cycle misaligned_o=1, wb_valid_o=1, wb_reg_we_o=0.
- Reset mid-load: rst=1 during WAIT_RVALID, then rvalid after deassertion -> all outputs at reset values, rvalid ignored, wb_valid_o stays 0.
